// File: rtl/ram_panel_pkg.sv
// Shared definitions for the RAM panel controller: switch mode encodings
// and the controller state type.
package ram_panel_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_CLEAR  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_READ,
    ST_SCAN,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and
// rising-edge detector on the debounced level.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the asynchronous button into the clock domain.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, whatever the block order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles the synchronised input disagrees with the level.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounced level, its counter and the delayed copy for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      prev_q  <= level_q;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~prev_q;

endmodule

// File: rtl/ram_panel_ctrl.sv
// Switch-and-button front end for an on-chip RAM: manual read/write,
// auto-scan display and clear-all sweep, all driven from one debounced key.
module ram_panel_ctrl
  import ram_panel_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int DEB_CYCLES = 16,
  parameter int SCAN_DIV   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btn_raw,
  input  logic [1:0]        sw_mode,
  input  logic              sw_wren,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  output logic              scanning,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(SCAN_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              wren_q, wren_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              rd_pend_q, rd_pend_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] dout_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;
  logic              dout_clr;

  logic              btn_level, btn_rise, step;
  logic [DATA_W-1:0] mem_q [DEPTH];

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clock(clock),
    .reset(reset),
    .raw  (btn_raw),
    .level(btn_level),
    .rise (btn_rise)
  );

  // A step is a fresh press while the debounced key is held down.
  assign step = btn_rise & btn_level;

  // Next-state logic, RAM port control and output-register updates.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    wren_d     = wren_q;
    wdata_d    = wdata_q;
    wr_ptr_d   = wr_ptr_q;
    div_d      = div_q;
    rd_pend_d  = 1'b0;
    done_d     = 1'b0;
    dout_clr   = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = cur_addr_q;
    mem_wdata  = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (step) begin
          case (sw_mode)
            MODE_SCAN: begin
              div_d   = '0;
              state_d = ST_SCAN;
            end
            MODE_CLEAR: begin
              wr_ptr_d = '0;
              state_d  = ST_CLEAR;
            end
            default: begin
              cur_addr_d = sw_addr;
              wren_d     = sw_wren;
              wdata_d    = sw_data;
              state_d    = ST_ACCESS;
            end
          endcase
        end
      end
      ST_ACCESS: begin
        mem_we  = wren_q;
        state_d = ST_READ;
      end
      ST_READ: begin
        state_d = ST_IDLE;
      end
      ST_SCAN: begin
        if (step || (sw_mode != MODE_SCAN)) begin
          state_d = ST_IDLE;
        end else if (div_q == DIV_MAX) begin
          div_d      = '0;
          cur_addr_d = cur_addr_q + 1'b1;
          rd_pend_d  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = wr_ptr_q;
        mem_wdata = '0;
        if (wr_ptr_q == ADDR_MAX) begin
          cur_addr_d = '0;
          dout_clr   = 1'b1;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads always target the displayed address: once in READ, and one cycle
  // after every scan step.
  assign rd_en = (state_q == ST_READ) || rd_pend_q;

  // Controller state and latched manual switch values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      wren_q     <= 1'b0;
      wdata_q    <= '0;
      wr_ptr_q   <= '0;
      div_q      <= '0;
      rd_pend_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      wren_q     <= wren_d;
      wdata_q    <= wdata_d;
      wr_ptr_q   <= wr_ptr_d;
      div_q      <= div_d;
      rd_pend_q  <= rd_pend_d;
      done_q     <= done_d;
    end
  end

  // RAM write port.
  // NOTE: the array has no reset so it maps onto plain RAM; its contents
  // survive reset, which is why a reset mid-sweep leaves it partly zeroed.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read data; the end of a clear sweep blanks the display.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
    end else if (dout_clr) begin
      dout_q <= '0;
    end else if (rd_en) begin
      dout_q <= mem_q[cur_addr_q];
    end
  end

  assign dout     = dout_q;
  assign cur_addr = cur_addr_q;
  assign busy     = (state_q == ST_ACCESS) || (state_q == ST_READ) || (state_q == ST_CLEAR);
  assign scanning = (state_q == ST_SCAN);
  assign done     = done_q;

endmodule

// File: tb/tb_ram_panel_ctrl.sv
// Directed bench for ram_panel_ctrl with DATA_W=8, ADDR_W=4, DEB_CYCLES=4,
// SCAN_DIV=3. Inputs change and outputs are sampled on the falling edge.
module tb_ram_panel_ctrl;

  logic       clock;
  logic       reset;
  logic       btn_raw;
  logic [1:0] sw_mode;
  logic       sw_wren;
  logic [3:0] sw_addr;
  logic [7:0] sw_data;
  logic [7:0] dout;
  logic [3:0] cur_addr;
  logic       busy;
  logic       scanning;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  ram_panel_ctrl #(
    .DATA_W    (8),
    .ADDR_W    (4),
    .DEB_CYCLES(4),
    .SCAN_DIV  (3)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (btn_raw),
    .sw_mode (sw_mode),
    .sw_wren (sw_wren),
    .sw_addr (sw_addr),
    .sw_data (sw_data),
    .dout    (dout),
    .cur_addr(cur_addr),
    .busy    (busy),
    .scanning(scanning),
    .done    (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  // Clean press and release, long enough for both debounced edges.
  task automatic press();
    btn_raw = 1'b1;
    repeat (12) tick();
    btn_raw = 1'b0;
    repeat (12) tick();
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    sw_mode = 2'b00;
    sw_wren = 1'b1;
    sw_addr = a;
    sw_data = d;
    press();
  endtask

  task automatic do_read(input logic [3:0] a, output logic [7:0] d);
    sw_mode = 2'b00;
    sw_wren = 1'b0;
    sw_addr = a;
    press();
    d = dout;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    btn_raw = 1'b0;
    sw_mode = 2'b00;
    sw_wren = 1'b0;
    sw_addr = '0;
    sw_data = '0;
    repeat (3) tick();
    n_tests++; if (dout !== 8'h00)    begin n_fail++; $display("FAIL reset_dout: got %h expected 00", dout); end
    n_tests++; if (cur_addr !== 4'h0) begin n_fail++; $display("FAIL reset_cur_addr: got %h expected 0", cur_addr); end
    n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (scanning !== 1'b0) begin n_fail++; $display("FAIL reset_scanning: got %b expected 0", scanning); end
    n_tests++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_bounce();
    int   rises;
    logic prev_busy;
    rises     = 0;
    prev_busy = busy;
    sw_mode   = 2'b00;
    sw_wren   = 1'b1;
    sw_addr   = 4'h0;
    sw_data   = 8'h01;
    for (int i = 0; i < 20; i++) begin
      btn_raw = ((i % 4) < 2);
      tick();
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
    end
    btn_raw = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
    end
    btn_raw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
    end
    n_tests++; if (rises !== 1)    begin n_fail++; $display("FAIL bounce_steps: got %0d expected 1", rises); end
    n_tests++; if (dout !== 8'h01) begin n_fail++; $display("FAIL bounce_dout: got %h expected 01", dout); end

    // A 3-cycle glitch is one cycle short of acceptance.
    rises   = 0;
    sw_data = 8'hEE;
    btn_raw = 1'b1;
    repeat (3) tick();
    btn_raw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
    end
    n_tests++; if (rises !== 0) begin n_fail++; $display("FAIL glitch_steps: got %0d expected 0", rises); end
  endtask

  task automatic test_manual();
    int         first, busy_cnt;
    logic [7:0] dout_mid, dout_end, rd;
    logic [3:0] cur_end;
    first    = 0;
    busy_cnt = 0;
    dout_mid = '0;
    dout_end = '0;
    cur_end  = '0;
    sw_mode  = 2'b00;
    sw_wren  = 1'b1;
    sw_addr  = 4'h5;
    sw_data  = 8'hA7;
    btn_raw  = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (busy) begin
        busy_cnt++;
        if (first == 0) first = k;
      end
      if (k == 8) dout_mid = dout;
      if (k == 9) begin
        dout_end = dout;
        cur_end  = cur_addr;
      end
      if (k == 15) btn_raw = 1'b0;
    end
    n_tests++; if (first !== 7)        begin n_fail++; $display("FAIL manual_step_latency: got %0d expected 7", first); end
    n_tests++; if (busy_cnt !== 2)     begin n_fail++; $display("FAIL manual_busy_cycles: got %0d expected 2", busy_cnt); end
    n_tests++; if (dout_mid !== 8'h01) begin n_fail++; $display("FAIL manual_dout_early: got %h expected 01", dout_mid); end
    n_tests++; if (dout_end !== 8'hA7) begin n_fail++; $display("FAIL manual_dout: got %h expected a7", dout_end); end
    n_tests++; if (cur_end !== 4'h5)   begin n_fail++; $display("FAIL manual_cur_addr: got %h expected 5", cur_end); end
    do_read(4'h5, rd);
    n_tests++; if (rd !== 8'hA7)       begin n_fail++; $display("FAIL manual_readback: got %h expected a7", rd); end
  endtask

  task automatic test_busy_drop();
    int         busy_cnt, changes;
    logic [7:0] prev_dout;
    busy_cnt  = 0;
    changes   = 0;
    prev_dout = dout;
    sw_mode   = 2'b00;
    sw_wren   = 1'b1;
    sw_addr   = 4'h3;
    sw_data   = 8'h5A;
    btn_raw   = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (busy) busy_cnt++;
      if (dout !== prev_dout) changes++;
      prev_dout = dout;
      // Switch changes and key chatter during the access must be ignored.
      if (k == 7) begin
        sw_addr = 4'h9;
        sw_data = 8'hFF;
      end
      if (k >= 8 && k < 18) btn_raw = ~btn_raw;
      if (k >= 18) btn_raw = 1'b0;
    end
    n_tests++; if (busy_cnt !== 2)  begin n_fail++; $display("FAIL busy_drop_busy_cycles: got %0d expected 2", busy_cnt); end
    n_tests++; if (changes !== 1)   begin n_fail++; $display("FAIL busy_drop_dout_changes: got %0d expected 1", changes); end
    n_tests++; if (dout !== 8'h5A)  begin n_fail++; $display("FAIL busy_drop_dout: got %h expected 5a", dout); end
    n_tests++; if (cur_addr !== 4'h3) begin n_fail++; $display("FAIL busy_drop_cur_addr: got %h expected 3", cur_addr); end
  endtask

  task automatic test_scan();
    logic [7:0] rd;
    logic [3:0] cur_t [13];
    logic [7:0] dout_t [13];
    logic       scan_t [13];
    int         waited;
    do_write(4'hF, 8'h3C);
    do_write(4'h0, 8'h11);
    do_write(4'h1, 8'h22);
    do_write(4'hE, 8'h5E);
    do_read(4'hE, rd);
    n_tests++; if (rd !== 8'h5E) begin n_fail++; $display("FAIL scan_preload: got %h expected 5e", rd); end

    sw_mode = 2'b01;
    btn_raw = 1'b1;
    waited  = 0;
    while (!scanning && waited < 20) begin
      tick();
      waited++;
    end
    n_tests++; if (!scanning) begin n_fail++; $display("FAIL scan_start: got scanning=%b expected 1 within 20 cycles", scanning); end
    cur_t[0]  = cur_addr;
    dout_t[0] = dout;
    scan_t[0] = scanning;
    for (int j = 1; j <= 12; j++) begin
      tick();
      cur_t[j]  = cur_addr;
      dout_t[j] = dout;
      scan_t[j] = scanning;
      if (j == 10) sw_mode = 2'b00;
    end
    n_tests++; if (cur_t[0] !== 4'hE)   begin n_fail++; $display("FAIL scan_entry_addr: got %h expected e", cur_t[0]); end
    n_tests++; if (cur_t[2] !== 4'hE)   begin n_fail++; $display("FAIL scan_hold_addr: got %h expected e", cur_t[2]); end
    n_tests++; if (cur_t[3] !== 4'hF)   begin n_fail++; $display("FAIL scan_addr_15: got %h expected f", cur_t[3]); end
    n_tests++; if (dout_t[3] !== 8'h5E) begin n_fail++; $display("FAIL scan_dout_lag: got %h expected 5e", dout_t[3]); end
    n_tests++; if (dout_t[4] !== 8'h3C) begin n_fail++; $display("FAIL scan_dout_15: got %h expected 3c", dout_t[4]); end
    n_tests++; if (cur_t[6] !== 4'h0)   begin n_fail++; $display("FAIL scan_addr_wrap: got %h expected 0", cur_t[6]); end
    n_tests++; if (dout_t[7] !== 8'h11) begin n_fail++; $display("FAIL scan_dout_0: got %h expected 11", dout_t[7]); end
    n_tests++; if (cur_t[9] !== 4'h1)   begin n_fail++; $display("FAIL scan_addr_1: got %h expected 1", cur_t[9]); end
    n_tests++; if (scan_t[10] !== 1'b1) begin n_fail++; $display("FAIL scan_running: got %b expected 1", scan_t[10]); end
    n_tests++; if (scan_t[11] !== 1'b0) begin n_fail++; $display("FAIL scan_stop: got %b expected 0", scan_t[11]); end
    n_tests++; if (dout_t[11] !== 8'h22) begin n_fail++; $display("FAIL scan_stop_dout: got %h expected 22", dout_t[11]); end
    n_tests++; if (cur_t[12] !== 4'h1)  begin n_fail++; $display("FAIL scan_stop_addr: got %h expected 1", cur_t[12]); end
    btn_raw = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_clear();
    logic [7:0] rd;
    int         waited, busy_cnt, done_cnt, done_j;
    logic       done_busy;
    logic [3:0] done_cur;
    logic [7:0] done_dout;
    for (int i = 0; i < 16; i++) do_write(4'(i), 8'(8'h80 + i));
    do_read(4'h9, rd);
    n_tests++; if (rd !== 8'h89) begin n_fail++; $display("FAIL clear_prefill: got %h expected 89", rd); end

    sw_mode = 2'b10;
    btn_raw = 1'b1;
    waited  = 0;
    while (!busy && waited < 20) begin
      tick();
      waited++;
    end
    n_tests++; if (!busy) begin n_fail++; $display("FAIL clear_start: got busy=%b expected 1 within 20 cycles", busy); end
    btn_raw   = 1'b0;
    busy_cnt  = busy ? 1 : 0;
    done_cnt  = 0;
    done_j    = 0;
    done_busy = 1'b1;
    done_cur  = 4'hX;
    done_dout = 8'hXX;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_j    = j;
        done_busy = busy;
        done_cur  = cur_addr;
        done_dout = dout;
      end
      if (j == 2) sw_mode = 2'b01;
      if (j == 4) sw_mode = 2'b10;
      if (j == 6) btn_raw = 1'b1;
      if (j == 25) btn_raw = 1'b0;
    end
    n_tests++; if (busy_cnt !== 16)     begin n_fail++; $display("FAIL clear_busy_cycles: got %0d expected 16", busy_cnt); end
    n_tests++; if (done_cnt !== 1)      begin n_fail++; $display("FAIL clear_done_pulses: got %0d expected 1", done_cnt); end
    n_tests++; if (done_j !== 16)       begin n_fail++; $display("FAIL clear_done_time: got %0d expected 16", done_j); end
    n_tests++; if (done_busy !== 1'b0)  begin n_fail++; $display("FAIL clear_done_busy: got %b expected 0", done_busy); end
    n_tests++; if (done_cur !== 4'h0)   begin n_fail++; $display("FAIL clear_done_cur_addr: got %h expected 0", done_cur); end
    n_tests++; if (done_dout !== 8'h00) begin n_fail++; $display("FAIL clear_done_dout: got %h expected 00", done_dout); end
    do_read(4'h0, rd);
    n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL clear_word0: got %h expected 00", rd); end
    do_read(4'h7, rd);
    n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL clear_word7: got %h expected 00", rd); end
    do_read(4'hF, rd);
    n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL clear_word15: got %h expected 00", rd); end
  endtask

  task automatic test_reset_mid_clear();
    logic [7:0] rd, exp;
    int         waited;
    for (int i = 0; i < 16; i++) do_write(4'(i), 8'(8'h40 + i));
    sw_mode = 2'b10;
    btn_raw = 1'b1;
    waited  = 0;
    while (!busy && waited < 20) begin
      tick();
      waited++;
    end
    n_tests++; if (!busy) begin n_fail++; $display("FAIL rst_clear_start: got busy=%b expected 1 within 20 cycles", busy); end
    btn_raw = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    #1;
    n_tests++; if (dout !== 8'h00)    begin n_fail++; $display("FAIL rst_clear_dout: got %h expected 00", dout); end
    n_tests++; if (cur_addr !== 4'h0) begin n_fail++; $display("FAIL rst_clear_cur_addr: got %h expected 0", cur_addr); end
    n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_clear_busy: got %b expected 0", busy); end
    n_tests++; if (scanning !== 1'b0) begin n_fail++; $display("FAIL rst_clear_scanning: got %b expected 0", scanning); end
    n_tests++; if (done !== 1'b0)     begin n_fail++; $display("FAIL rst_clear_done: got %b expected 0", done); end
    sw_mode = 2'b00;
    repeat (3) tick();
    reset = 1'b0;
    repeat (12) tick();
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i), rd);
      exp = (i < 6) ? 8'h00 : 8'(8'h40 + i);
      n_tests++;
      if (rd !== exp) begin
        n_fail++;
        $display("FAIL rst_clear_word%0d: got %h expected %h", i, rd, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_manual();
    test_busy_drop();
    test_scan();
    test_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
